// File: rtl/cms_trace_receiver.sv
// cms_trace_receiver: AXI-Stream trace beat receiver with FIFO buffering, beat/packet counters and optional tlast framing checker.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   S_AXIS_tvalid/tready/tdata/tlast - input stream; tdata = {pc[XLEN-1:0], instr[31:0]}
//   tlast_interval                  - expected beats per packet (0 is treated as 1)
//   out_valid/out_ready             - head-of-FIFO handshake
//   out_pc/out_instr/out_last       - head entry fields (zero while empty)
//   beat_count, packet_count        - accepted beats / accepted tlast beats since reset
//   tlast_error, error_count        - sticky framing error flag / framing error count
// Build option: define CMS_RX_TLAST_CHECK_EN to include the framing checker;
// without it tlast_error and error_count are held at 0.
module cms_trace_receiver #(
  parameter int XLEN           = 64,
  parameter int AXI_DATA_WIDTH = XLEN + 32,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      S_AXIS_tvalid,
  output logic                      S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                      S_AXIS_tlast,
  input  logic [31:0]               tlast_interval,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_instr,
  output logic                      out_last,
  output logic [31:0]               beat_count,
  output logic [31:0]               packet_count,
  output logic                      tlast_error,
  output logic [31:0]               error_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = XLEN + 33;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          ready_en, full, empty, push, pop;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  // ready_en holds tready low during reset and releases it on the first edge after.
  assign S_AXIS_tready = ready_en & ~full;
  assign out_valid     = ~empty;
  assign push          = S_AXIS_tvalid & S_AXIS_tready;
  assign pop           = out_valid & out_ready;
  assign head          = mem[rd_ptr[AW-1:0]];
  assign out_pc        = out_valid ? head[EW-1:33] : '0;
  assign out_instr     = out_valid ? head[32:1] : '0;
  assign out_last      = out_valid & head[0];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {S_AXIS_tdata[32 +: XLEN], S_AXIS_tdata[31:0], S_AXIS_tlast};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ready_en     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      beat_count   <= '0;
      packet_count <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) beat_count <= beat_count + 32'd1;
      if (push && S_AXIS_tlast) packet_count <= packet_count + 32'd1;
    end
`ifdef CMS_RX_TLAST_CHECK_EN
  typedef enum logic [1:0] {RX_IDLE, RX_PACKET, RX_RESYNC} rx_state_t;
  rx_state_t   state, state_nxt;
  logic [31:0] idx, idx_nxt, exp_idx;
  logic        at_end, err;
  assign exp_idx = (tlast_interval == 32'd0) ? 32'd0 : tlast_interval - 32'd1;
  // A tlast on or past the expected index closes the packet cleanly.
  assign at_end  = idx >= exp_idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= RX_IDLE;
      idx         <= '0;
      tlast_error <= 1'b0;
      error_count <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (err) tlast_error <= 1'b1;
      if (err) error_count <= error_count + 32'd1;
    end
  always_comb
    state_nxt = !push ? state :
                (state == RX_RESYNC) ? (S_AXIS_tlast ? RX_IDLE : RX_RESYNC) :
                S_AXIS_tlast ? RX_IDLE : at_end ? RX_RESYNC : RX_PACKET;
  // Early tlast and missing tlast are both errors; RX_RESYNC reports nothing further.
  always_comb begin
    err     = push && (state != RX_RESYNC) && (S_AXIS_tlast ? !at_end : at_end);
    idx_nxt = !push ? idx : (state_nxt == RX_PACKET) ? idx + 32'd1 : 32'd0;
  end
`else
  logic unused_interval;
  assign unused_interval = ^tlast_interval;
  assign tlast_error     = 1'b0;
  assign error_count     = '0;
`endif
endmodule

// File: tb/tb_cms_trace_receiver.sv
// tb_cms_trace_receiver: directed table and sequence bench for cms_trace_receiver.
module tb_cms_trace_receiver;
`ifdef CMS_RX_TLAST_CHECK_EN
  localparam logic [63:0] CHK = 64'd1;
`else
  localparam logic [63:0] CHK = 64'd0;
`endif
  logic        clk, rst_n, tvalid, tready, tlast, out_valid, out_ready, out_last, tlast_error;
  logic [95:0] tdata;
  logic [31:0] interval, out_instr, beat_count, packet_count, error_count;
  logic [63:0] out_pc;
  int tests, fails;
  typedef struct {
    logic v, l, r;
    logic [63:0] pc;
    logic [31:0] in, iv;
    logic ov, ol;
    logic [63:0] opc;
    logic [31:0] oi, bc, pk;
  } vec_t;
  vec_t tbl[10];
  cms_trace_receiver dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(tvalid), .S_AXIS_tready(tready), .S_AXIS_tdata(tdata), .S_AXIS_tlast(tlast),
    .tlast_interval(interval),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_last(out_last),
    .beat_count(beat_count), .packet_count(packet_count), .tlast_error(tlast_error), .error_count(error_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0; out_ready = 1'b0;
    repeat (2) tick();
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_beats", 64'(beat_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_tready_low", 64'(tready), 64'd0);
    tick();
    chk("rel_tready_high", 64'(tready), 64'd1);
  endtask
  task automatic beat(input logic [63:0] pc, input logic [31:0] ins, input logic l);
    int w;
    tvalid = 1'b1; tlast = l; tdata = {pc, ins};
    w = 0;
    while (!tready && w < 20) begin
      tick();
      w++;
    end
    if (w == 20) chk("tready_timeout", 64'(tready), 64'd1);
    tick();
    tvalid = 1'b0; tlast = 1'b0;
  endtask
  initial begin
    int acc;
    logic a;
    tests = 0; fails = 0; interval = 32'd3;
    tbl[0] = '{1'b1, 1'b0, 1'b1, 64'd8,    32'h108, 32'd3, 1'b1, 1'b0, 64'd8,    32'h108, 32'd1, 32'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 64'd12,   32'h10c, 32'd3, 1'b1, 1'b0, 64'd12,   32'h10c, 32'd2, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 64'd16,   32'h110, 32'd3, 1'b1, 1'b1, 64'd16,   32'h110, 32'd3, 32'd1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 64'd20,   32'h114, 32'd3, 1'b1, 1'b0, 64'd20,   32'h114, 32'd4, 32'd1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 64'd24,   32'h118, 32'd3, 1'b1, 1'b0, 64'd24,   32'h118, 32'd5, 32'd1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 64'd28,   32'h11c, 32'd3, 1'b1, 1'b1, 64'd28,   32'h11c, 32'd6, 32'd2};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 64'd0,    32'h0,   32'd3, 1'b0, 1'b0, 64'd0,    32'h0,   32'd6, 32'd2};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 64'h10,   32'h6f,  32'd1, 1'b1, 1'b1, 64'h10,   32'h6f,  32'd7, 32'd3};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 64'd0,    32'h0,   32'd1, 1'b1, 1'b1, 64'h10,   32'h6f,  32'd7, 32'd3};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 64'd0,    32'h0,   32'd1, 1'b0, 1'b0, 64'd0,    32'h0,   32'd7, 32'd3};
    do_reset();
    chk("rst_out_pc", out_pc, 64'd0);
    for (int i = 0; i < 10; i++) begin
      tvalid = tbl[i].v; tlast = tbl[i].l; out_ready = tbl[i].r;
      tdata = {tbl[i].pc, tbl[i].in}; interval = tbl[i].iv;
      tick();
      chk($sformatf("r%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("r%0d_out_pc", i), out_pc, tbl[i].opc);
      chk($sformatf("r%0d_out_instr", i), 64'(out_instr), 64'(tbl[i].oi));
      chk($sformatf("r%0d_out_last", i), 64'(out_last), 64'(tbl[i].ol));
      chk($sformatf("r%0d_beats", i), 64'(beat_count), 64'(tbl[i].bc));
      chk($sformatf("r%0d_packets", i), 64'(packet_count), 64'(tbl[i].pk));
      chk($sformatf("r%0d_errors", i), 64'(error_count), 64'd0);
      chk($sformatf("r%0d_tready", i), 64'(tready), 64'd1);
    end
    // Fill to full with the consumer stalled, then free one slot.
    do_reset();
    interval = 32'd0; out_ready = 1'b0; tvalid = 1'b1; tlast = 1'b1; acc = 0;
    for (int i = 0; i < 12; i++) begin
      tdata = {64'(acc), 32'h13};
      a = tready;
      tick();
      if (a) acc++;
    end
    chk("full_accepts", 64'(acc), 64'd8);
    chk("full_tready", 64'(tready), 64'd0);
    chk("full_beats", 64'(beat_count), 64'd8);
    out_ready = 1'b1;
    tick();
    chk("pop_tready", 64'(tready), 64'd1);
    out_ready = 1'b0;
    tick();
    chk("ninth_beats", 64'(beat_count), 64'd9);
    chk("ninth_tready", 64'(tready), 64'd0);
    tvalid = 1'b0; tlast = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("drain%0d_pc", k), out_pc, 64'(k));
      tick();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("full_packets", 64'(packet_count), 64'd9);
    chk("full_errors", 64'(error_count), 64'd0);
    // Early tlast: error, then the next beat restarts at index 0.
    do_reset();
    interval = 32'd3; out_ready = 1'b1;
    beat(64'h100, 32'h1, 1'b0);
    beat(64'h104, 32'h2, 1'b1);
    chk("early_flag", 64'(tlast_error), CHK);
    chk("early_count", 64'(error_count), CHK);
    beat(64'h108, 32'h3, 1'b0);
    beat(64'h10c, 32'h4, 1'b0);
    beat(64'h110, 32'h5, 1'b1);
    chk("early_after_count", 64'(error_count), CHK);
    chk("early_packets", 64'(packet_count), 64'd2);
    // Missing tlast: one error, resync on the late tlast, then a clean packet.
    do_reset();
    interval = 32'd3; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) beat(64'(i * 4), 32'h13, 1'b0);
    beat(64'h14, 32'h13, 1'b1);
    chk("missing_count", 64'(error_count), CHK);
    beat(64'h18, 32'h13, 1'b0);
    beat(64'h1c, 32'h13, 1'b0);
    beat(64'h20, 32'h13, 1'b1);
    chk("resync_count", 64'(error_count), CHK);
    chk("resync_flag", 64'(tlast_error), CHK);
    chk("resync_beats", 64'(beat_count), 64'd9);
    chk("resync_packets", 64'(packet_count), 64'd2);
    // Asynchronous reset with entries buffered mid-packet.
    do_reset();
    interval = 32'd8; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(64'(i + 64'h40), 32'h13, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_beats", 64'(beat_count), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_beats", 64'(beat_count), 64'd0);
    chk("async_tready", 64'(tready), 64'd0);
    chk("async_pc", out_pc, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_beats", 64'(beat_count), 64'd0);
    chk("post_rst_packets", 64'(packet_count), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cms_trace_receiver.md
CMS_TRACE_RECEIVER -- requirements
Module: cms_trace_receiver

Interface
REQ-001 SHALL have parameter XLEN, default 64, program-counter width in bits.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default XLEN+32, stream beat width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, buffer entries; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port S_AXIS_tvalid  input  1  producer beat valid.
REQ-007 SHALL have port S_AXIS_tready  output  1  receiver can accept a beat.
REQ-008 SHALL have port S_AXIS_tdata  input  AXI_DATA_WIDTH  beat payload: [AXI_DATA_WIDTH-1:32]=pc, [31:0]=instr.
REQ-009 SHALL have port S_AXIS_tlast  input  1  last beat of packet.
REQ-010 SHALL have port tlast_interval  input  32  expected beats per packet.
REQ-011 SHALL have port out_valid  output  1  buffered entry available.
REQ-012 SHALL have port out_ready  input  1  consumer pops head entry.
REQ-013 SHALL have port out_pc  output  XLEN  pc field of head entry.
REQ-014 SHALL have port out_instr  output  32  instr field of head entry.
REQ-015 SHALL have port out_last  output  1  tlast stored with head entry.
REQ-016 SHALL have port beat_count  output  32  accepted beats since reset.
REQ-017 SHALL have port packet_count  output  32  accepted tlast beats since reset.
REQ-018 SHALL have port tlast_error  output  1  sticky framing error flag.
REQ-019 SHALL have port error_count  output  32  framing errors since reset.

Function
REQ-020 SHALL accept a beat exactly on a rising edge where S_AXIS_tvalid and S_AXIS_tready are both 1.
REQ-021 SHALL drive S_AXIS_tready = 1 whenever the FIFO is not full and 0 when it holds FIFO_DEPTH entries, independent of S_AXIS_tvalid.
REQ-022 SHALL write {pc, instr, tlast} of each accepted beat into the FIFO; out_valid rises the cycle after acceptance into an empty FIFO (1-cycle latency).
REQ-023 SHALL present the head entry on out_pc/out_instr/out_last while out_valid=1 and pop it on a rising edge with out_valid and out_ready both 1.
REQ-024 SHALL support simultaneous push and pop in one cycle with occupancy unchanged; when full, pop frees space and tready rises the next cycle.
REQ-025 SHALL keep out_pc/out_instr/out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL wrap beat_count, packet_count and error_count modulo 2^32.
REQ-027 SHALL track position with a 32-bit beat index and a framing FSM with states RX_IDLE (index 0), RX_PACKET (mid-packet), RX_RESYNC (lost framing).
REQ-028 SHALL treat tlast_interval = 0 as 1; expected-last beat is index = max(tlast_interval,1)-1, sampled on each accepted beat.
REQ-029 RX_IDLE/RX_PACKET: accepted beat with tlast at expected index -> RX_IDLE, index 0; without tlast before expected index -> RX_PACKET, index+1.
REQ-030 RX_IDLE/RX_PACKET: tlast before expected index (early) -> error, RX_IDLE, index 0.
REQ-031 RX_IDLE/RX_PACKET: no tlast at expected index (missing) -> error, RX_RESYNC.
REQ-032 RX_RESYNC: beats without tlast stay in RX_RESYNC with no further error; beat with tlast -> RX_IDLE, index 0.
REQ-033 SHALL on each error set tlast_error (sticky until reset) and increment error_count by 1 in the same edge.
REQ-034 SHALL buffer every accepted beat regardless of framing errors; framing never stalls tready.

Reset
REQ-035 SHALL on rst_n=0 asynchronously clear FIFO pointers and counters, force S_AXIS_tready=0, out_valid=0, out_pc=0, out_instr=0, out_last=0, all counts 0, tlast_error=0, FSM RX_IDLE.
REQ-036 SHALL raise S_AXIS_tready on the first rising edge after rst_n deasserts; reset mid-packet discards buffered entries and partial framing.

Configuration
REQ-037 SHALL compile framing checker (REQ-027..REQ-033) only when CMS_RX_TLAST_CHECK_EN is defined; without it, tlast_error and error_count are constant 0, tlast_interval is ignored, and buffering, beat_count and packet_count behave identically.

Verification
REQ-038 SHALL verify: interval=3, 6 beats pc=8,12,..,28, tlast on beats 3 and 6, out_ready=1 -> same order out, packet_count=2, error_count=0.
REQ-039 SHALL verify: out_ready=0, tvalid=1 continuously, depth 8 -> tready low after 8th accept; out_ready=1 one cycle -> tready high next cycle, 9th beat accepted.
REQ-040 SHALL verify: interval=3, tlast on 2nd beat -> tlast_error=1, error_count=1, next beat treated as index 0.
REQ-041 SHALL verify: interval=3, no tlast for 5 beats then tlast on 6th -> error_count=1 (RX_RESYNC), then clean 3-beat packet -> error_count stays 1.
REQ-042 SHALL verify: rst_n pulsed low with 4 entries buffered mid-packet -> out_valid=0 and all counts 0 immediately, no stale data after release.
REQ-043 SHALL verify: instr=32'h0000006f, pc=64'h10 with tlast -> out_instr=32'h0000006f, out_pc=64'h10, out_last=1.
